// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
//   - FSM state encoding (S_FETCH=0 .. S_JUMP=8)
//   - ALU operation codes, NPC select, GPR write-address select and
//     write-data select encodings shared with the single-cycle CPU
//   - opcode / funct values of the supported ISA subset
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  // ALU operations
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // Next-PC source
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JUMPR  = 2'b11;

  // Register-file write address source
  localparam logic [1:0] GPRSel_RD = 2'b00;
  localparam logic [1:0] GPRSel_RT = 2'b01;
  localparam logic [1:0] GPRSel_31 = 2'b10;

  // Register-file write data source
  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction decoder for mc_ctrl.
// Ports:
//   op, funct            in   instruction opcode and funct fields
//   cls_alu              out  R-type ALU op, shift or ALU immediate (EXE path)
//   is_rtype             out  opcode is SPECIAL (R-type format)
//   is_lw .. is_jalr     out  one-hot per memory / control-flow instruction
//   illegal              out  op/funct combination is not decoded
//   alu_op, ext_op,      out  per-instruction datapath controls, shared by
//   alu_a, alu_src            the EXE, MEMADR and BRANCH states
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       cls_alu,
  output logic       is_rtype,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_j,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_jalr,
  output logic       illegal,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       alu_a,
  output logic       alu_src
);

  // Opcode/funct decode into instruction class and ALU controls
  always_comb begin
    cls_alu  = 1'b0;
    is_rtype = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    is_jalr  = 1'b0;
    illegal  = 1'b0;
    alu_op   = ALU_NOP;
    ext_op   = 1'b0;
    alu_a    = 1'b0;
    alu_src  = 1'b0;
    case (op)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: begin cls_alu = 1'b1; alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin cls_alu = 1'b1; alu_op = ALU_SUB;  end
          FN_AND:          begin cls_alu = 1'b1; alu_op = ALU_AND;  end
          FN_OR:           begin cls_alu = 1'b1; alu_op = ALU_OR;   end
          FN_NOR:          begin cls_alu = 1'b1; alu_op = ALU_NOR;  end
          FN_SLT:          begin cls_alu = 1'b1; alu_op = ALU_SLT;  end
          FN_SLTU:         begin cls_alu = 1'b1; alu_op = ALU_SLTU; end
          // Constant shifts take their amount from the shamt field
          FN_SLL: begin cls_alu = 1'b1; alu_op = ALU_SLL; alu_a = 1'b1; end
          FN_SRL: begin cls_alu = 1'b1; alu_op = ALU_SRL; alu_a = 1'b1; end
          FN_JR:           is_jr   = 1'b1;
          FN_JALR:         is_jalr = 1'b1;
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin cls_alu = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1; end
      OP_SLTI: begin cls_alu = 1'b1; alu_op = ALU_SLT; ext_op = 1'b1; alu_src = 1'b1; end
      OP_ANDI: begin cls_alu = 1'b1; alu_op = ALU_AND; alu_src = 1'b1; end
      OP_ORI:  begin cls_alu = 1'b1; alu_op = ALU_OR;  alu_src = 1'b1; end
      OP_LUI:  begin cls_alu = 1'b1; alu_op = ALU_LUI; alu_src = 1'b1; end
      // Loads and stores compute base + sign-extended offset
      OP_LW:   begin is_lw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1; end
      OP_SW:   begin is_sw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1; end
      // Branches compare rs and rt by subtraction
      OP_BEQ:  begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; alu_op = ALU_SUB; end
      OP_J:    is_j   = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for the MIPS multicycle CPU.
// Sequences FETCH / DECODE / EXE / MEMADR / MEMRD / MEMWR / WB / BRANCH /
// JUMP over a shared datapath, stalling on mem_ready in the memory states.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   Op, Funct            instruction fields from IR
//   Zero                 ALU zero flag (used in BRANCH)
//   mem_ready            memory completes the current access this cycle
//   PCWrite .. WDSel     datapath enables and mux selects
//   illegal              pulse when DECODE sees an undecoded instruction
//   retire               pulse on the last cycle of each legal instruction
//   state                current FSM state
//   instret              retired-instruction counter (wraps)
// All outputs are forced to zero while rst is high, so an in-flight memory
// strobe drops in the same cycle reset is asserted.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IorD,
  output logic                 RegWrite,
  output logic                 ALU_A,
  output logic                 ALUSrc,
  output logic                 EXTOp,
  output logic [3:0]           ALUOp,
  output logic [1:0]           NPCOp,
  output logic [1:0]           GPRSel,
  output logic [1:0]           WDSel,
  output logic                 illegal,
  output logic                 retire,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state_r;
  state_t                next_s;
  logic [INSTRET_W-1:0]  instret_r;

  logic       dec_alu_s, dec_rtype_s, dec_lw_s, dec_sw_s;
  logic       dec_beq_s, dec_bne_s, dec_j_s, dec_jal_s, dec_jr_s, dec_jalr_s;
  logic       dec_illegal_s;
  logic [3:0] dec_alu_op_s;
  logic       dec_ext_op_s, dec_alu_a_s, dec_alu_src_s;

  logic       pc_write_s, ir_write_s, mem_read_s, mem_write_s, iord_s;
  logic       reg_write_s, alu_a_s, alu_src_s, ext_op_s;
  logic [3:0] alu_op_s;
  logic [1:0] npc_op_s, gpr_sel_s, wd_sel_s;
  logic       illegal_s, retire_s;

  mc_decode u_decode (
    .op      (Op),
    .funct   (Funct),
    .cls_alu (dec_alu_s),
    .is_rtype(dec_rtype_s),
    .is_lw   (dec_lw_s),
    .is_sw   (dec_sw_s),
    .is_beq  (dec_beq_s),
    .is_bne  (dec_bne_s),
    .is_j    (dec_j_s),
    .is_jal  (dec_jal_s),
    .is_jr   (dec_jr_s),
    .is_jalr (dec_jalr_s),
    .illegal (dec_illegal_s),
    .alu_op  (dec_alu_op_s),
    .ext_op  (dec_ext_op_s),
    .alu_a   (dec_alu_a_s),
    .alu_src (dec_alu_src_s)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      instret_r <= {INSTRET_W{1'b0}};
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_s      = state_r;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    iord_s      = 1'b0;
    reg_write_s = 1'b0;
    alu_a_s     = 1'b0;
    alu_src_s   = 1'b0;
    ext_op_s    = 1'b0;
    alu_op_s    = ALU_NOP;
    npc_op_s    = NPC_PLUS4;
    gpr_sel_s   = GPRSel_RD;
    wd_sel_s    = WDSel_FromALU;
    illegal_s   = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b0;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          npc_op_s   = NPC_PLUS4;
          next_s     = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_lw_s || dec_sw_s) begin
          next_s = S_MEMADR;
        end else if (dec_alu_s) begin
          next_s = S_EXE;
        end else if (dec_beq_s || dec_bne_s) begin
          next_s = S_BRANCH;
        end else if (dec_j_s || dec_jal_s || dec_jr_s || dec_jalr_s) begin
          next_s = S_JUMP;
        end else begin
          // Undecoded instruction: drop it without retiring
          illegal_s = 1'b1;
          next_s    = S_FETCH;
        end
      end
      S_EXE: begin
        alu_op_s  = dec_alu_op_s;
        alu_a_s   = dec_alu_a_s;
        alu_src_s = dec_alu_src_s;
        ext_op_s  = dec_ext_op_s;
        next_s    = S_WB;
      end
      S_WB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_s      = S_FETCH;
        if (dec_lw_s) begin
          wd_sel_s = WDSel_FromMEM;
        end else begin
          wd_sel_s = WDSel_FromALU;
        end
        if (dec_rtype_s) begin
          gpr_sel_s = GPRSel_RD;
        end else begin
          gpr_sel_s = GPRSel_RT;
        end
        // Keep the ALU configured so an unregistered result stays valid
        if (dec_alu_s) begin
          alu_op_s  = dec_alu_op_s;
          alu_a_s   = dec_alu_a_s;
          alu_src_s = dec_alu_src_s;
          ext_op_s  = dec_ext_op_s;
        end else begin
          alu_op_s  = ALU_NOP;
        end
      end
      S_MEMADR: begin
        alu_op_s  = ALU_ADD;
        alu_src_s = 1'b1;
        ext_op_s  = 1'b1;
        if (dec_lw_s) begin
          next_s = S_MEMRD;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (mem_ready) begin
          next_s = S_WB;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          next_s   = S_FETCH;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_BRANCH: begin
        alu_op_s   = ALU_SUB;
        npc_op_s   = NPC_BRANCH;
        pc_write_s = (dec_beq_s & Zero) | (dec_bne_s & ~Zero);
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
        if (dec_jr_s || dec_jalr_s) begin
          npc_op_s = NPC_JUMPR;
        end else begin
          npc_op_s = NPC_JUMP;
        end
        // Link value is the PC, which already holds PC+4 from FETCH
        if (dec_jal_s) begin
          reg_write_s = 1'b1;
          gpr_sel_s   = GPRSel_31;
          wd_sel_s    = WDSel_FromPC;
        end else if (dec_jalr_s) begin
          reg_write_s = 1'b1;
          gpr_sel_s   = GPRSel_RD;
          wd_sel_s    = WDSel_FromPC;
        end else begin
          reg_write_s = 1'b0;
        end
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Output stage: everything reads zero while reset is held
  always_comb begin
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      ALU_A    = 1'b0;
      ALUSrc   = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = 4'd0;
      NPCOp    = 2'b00;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
      illegal  = 1'b0;
      retire   = 1'b0;
      state    = 4'd0;
      instret  = {INSTRET_W{1'b0}};
    end else begin
      PCWrite  = pc_write_s;
      IRWrite  = ir_write_s;
      MemRead  = mem_read_s;
      MemWrite = mem_write_s;
      IorD     = iord_s;
      RegWrite = reg_write_s;
      ALU_A    = alu_a_s;
      ALUSrc   = alu_src_s;
      EXTOp    = ext_op_s;
      ALUOp    = alu_op_s;
      NPCOp    = npc_op_s;
      GPRSel   = gpr_sel_s;
      WDSel    = wd_sel_s;
      illegal  = illegal_s;
      retire   = retire_s;
      state    = state_r;
      instret  = instret_r;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// An instruction table gives, per instruction, the expected class and the
// control values of its key cycles; each instruction class expands into a
// list of phases, and memory phases repeat while mem_ready is low.
module tb_mc_ctrl;

  localparam int S_F = 0, S_D = 1, S_E = 2, S_MA = 3, S_MR = 4,
                 S_MW = 5, S_WB = 6, S_B = 7, S_J = 8;
  localparam int C_ALUR = 0, C_ALUI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                 C_BNE = 5, C_J = 6, C_JAL = 7, C_JR = 8, C_JALR = 9,
                 C_ILL = 10;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         cls;
    logic [3:0] alu;
    logic       ext;
    logic       alua;
    logic       src;
    logic       rw;
    logic [1:0] gpr;
    logic [1:0] wd;
    logic [1:0] npc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Op, Funct;
  logic        Zero, mem_ready;
  logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite;
  logic        ALU_A, ALUSrc, EXTOp;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOp, GPRSel, WDSel;
  logic        illegal, retire;
  logic [3:0]  state;
  logic [31:0] instret;

  int   checks = 0;
  int   errors = 0;
  int   exp_instret = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mc_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .ALU_A(ALU_A), .ALUSrc(ALUSrc), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
    .illegal(illegal), .retire(retire), .state(state), .instret(instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_v(input logic [5:0] op, input logic [5:0] fn, input int cls,
                       input logic [3:0] alu, input logic ext, input logic alua,
                       input logic src, input logic rw, input logic [1:0] gpr,
                       input logic [1:0] wd, input logic [1:0] npc);
    vec_t v;
    v.op = op; v.funct = fn; v.cls = cls; v.alu = alu; v.ext = ext;
    v.alua = alua; v.src = src; v.rw = rw; v.gpr = gpr; v.wd = wd; v.npc = npc;
    tbl.push_back(v);
  endtask

  function automatic int base_cycles(input int cls);
    case (cls)
      C_ALUR, C_ALUI, C_SW: return 4;
      C_LW:                 return 5;
      C_ILL:                return 2;
      default:              return 3;
    endcase
  endfunction

  // Phase list of an instruction class
  task automatic build_seq(input int cls, output int seq[6], output int n);
    seq = '{S_F, S_D, 0, 0, 0, 0};
    case (cls)
      C_ALUR, C_ALUI: begin seq[2] = S_E;  seq[3] = S_WB; n = 4; end
      C_LW: begin seq[2] = S_MA; seq[3] = S_MR; seq[4] = S_WB; n = 5; end
      C_SW: begin seq[2] = S_MA; seq[3] = S_MW; n = 4; end
      C_BEQ, C_BNE: begin seq[2] = S_B; n = 3; end
      C_ILL: n = 2;
      default: begin seq[2] = S_J; n = 3; end
    endcase
  endtask

  function automatic bit is_mem(input int st);
    return (st == S_F) || (st == S_MR) || (st == S_MW);
  endfunction

  // Run one instruction from FETCH back to FETCH, checking every cycle
  task automatic run_instr(input int idx, input logic z, input bit rnd,
                           input int stall_st, input int stall_n, output int cycles);
    vec_t v;
    int   seq[6];
    int   n;
    int   i;
    int   stalled;
    bit   mr;
    bit   adv;
    bit   last;
    logic exp_pcw;
    v = tbl[idx];
    build_seq(v.cls, seq, n);
    i = 0; stalled = 0; cycles = 0;
    Op = v.op;
    Funct = (v.op == 6'd0 || !rnd) ? v.funct : 6'($urandom_range(0, 63));
    while (i < n && cycles < 64) begin
      @(negedge clk);
      Zero = z;
      mr = 1'b1;
      if (seq[i] == stall_st && stalled < stall_n) begin
        mr = 1'b0;
        stalled++;
      end else if (rnd && is_mem(seq[i])) begin
        mr = ($urandom_range(0, 3) != 0);
      end else begin
        mr = 1'b1;
      end
      mem_ready = mr;
      #1;
      adv  = !(is_mem(seq[i]) && !mr);
      last = adv && (i == n - 1);
      chk("state", state, seq[i]);
      chk("MemRead", MemRead, (seq[i] == S_F) || (seq[i] == S_MR));
      chk("MemWrite", MemWrite, seq[i] == S_MW);
      chk("IorD", IorD, (seq[i] == S_MR) || (seq[i] == S_MW));
      chk("illegal", illegal, (v.cls == C_ILL) && (seq[i] == S_D));
      chk("retire", retire, last && (v.cls != C_ILL));
      if (seq[i] == S_F) begin
        chk("fetch_IRWrite", IRWrite, mr);
        chk("fetch_PCWrite", PCWrite, mr);
        chk("fetch_NPCOp", NPCOp, 2'b00);
      end
      if (seq[i] == S_E || seq[i] == S_MA ||
          (seq[i] == S_WB && (v.cls == C_ALUR || v.cls == C_ALUI))) begin
        chk("ALUOp", ALUOp, v.alu);
        chk("EXTOp", EXTOp, v.ext);
        chk("ALU_A", ALU_A, v.alua);
        chk("ALUSrc", ALUSrc, v.src);
      end
      if (seq[i] == S_B) chk("branch_ALUOp", ALUOp, 4'd2);
      if (seq[i] == S_D) chk("decode_RegWrite", RegWrite, 1'b0);
      if (last && v.cls != C_ILL) begin
        case (v.cls)
          C_BEQ:                     exp_pcw = z;
          C_BNE:                     exp_pcw = !z;
          C_J, C_JAL, C_JR, C_JALR:  exp_pcw = 1'b1;
          default:                   exp_pcw = 1'b0;
        endcase
        chk("final_PCWrite", PCWrite, exp_pcw);
        chk("final_NPCOp", NPCOp, v.npc);
        chk("final_RegWrite", RegWrite, v.rw);
        chk("final_GPRSel", GPRSel, v.gpr);
        chk("final_WDSel", WDSel, v.wd);
        exp_instret++;
      end
      cycles++;
      if (adv) i++;
    end
    if (i < n) chk("timeout", i, n);
    @(posedge clk);
    #1;
    chk("instret", instret, exp_instret);
  endtask

  function automatic int find_op(input logic [5:0] op, input logic [5:0] fn);
    foreach (tbl[k]) if (tbl[k].op == op && (op != 6'd0 || tbl[k].funct == fn)) return k;
    return 0;
  endfunction

  initial begin
    int cyc;
    int idx;
    //    op     funct  class   alu  ext alua src rw  gpr    wd     npc
    add_v(6'h00, 6'h20, C_ALUR, 4'd1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // add
    add_v(6'h00, 6'h21, C_ALUR, 4'd1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // addu
    add_v(6'h00, 6'h22, C_ALUR, 4'd2, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // sub
    add_v(6'h00, 6'h23, C_ALUR, 4'd2, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // subu
    add_v(6'h00, 6'h24, C_ALUR, 4'd3, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // and
    add_v(6'h00, 6'h25, C_ALUR, 4'd4, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // or
    add_v(6'h00, 6'h27, C_ALUR, 4'd5, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // nor
    add_v(6'h00, 6'h2a, C_ALUR, 4'd6, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // slt
    add_v(6'h00, 6'h2b, C_ALUR, 4'd7, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00); // sltu
    add_v(6'h00, 6'h00, C_ALUR, 4'd8, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00); // sll
    add_v(6'h00, 6'h02, C_ALUR, 4'd9, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00); // srl
    add_v(6'h08, 6'h00, C_ALUI, 4'd1, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00); // addi
    add_v(6'h0c, 6'h00, C_ALUI, 4'd3, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00); // andi
    add_v(6'h0d, 6'h00, C_ALUI, 4'd4, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00); // ori
    add_v(6'h0a, 6'h00, C_ALUI, 4'd6, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00); // slti
    add_v(6'h0f, 6'h00, C_ALUI, 4'd10, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00); // lui
    add_v(6'h23, 6'h00, C_LW,   4'd1, 1, 0, 1, 1, 2'b01, 2'b01, 2'b00); // lw
    add_v(6'h2b, 6'h00, C_SW,   4'd1, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00); // sw
    add_v(6'h04, 6'h00, C_BEQ,  4'd2, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01); // beq
    add_v(6'h05, 6'h00, C_BNE,  4'd2, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01); // bne
    add_v(6'h02, 6'h00, C_J,    4'd0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10); // j
    add_v(6'h03, 6'h00, C_JAL,  4'd0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b10); // jal
    add_v(6'h00, 6'h08, C_JR,   4'd0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11); // jr
    add_v(6'h00, 6'h09, C_JALR, 4'd0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b11); // jalr
    add_v(6'h3f, 6'h00, C_ILL,  4'd0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00); // bad op
    add_v(6'h00, 6'h3f, C_ILL,  4'd0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00); // bad funct
    add_v(6'h01, 6'h00, C_ILL,  4'd0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00); // regimm

    // Reset: outputs zero before and after the first reset edge
    rst = 1'b1; mem_ready = 1'b1; Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
    #1;
    chk("rst_state_pre", state, 4'd0);
    chk("rst_MemRead_pre", MemRead, 1'b0);
    chk("rst_IRWrite_pre", IRWrite, 1'b0);
    @(posedge clk); #1;
    chk("rst_state", state, 4'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_PCWrite", PCWrite, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;

    // add $3,$1,$2: four cycles, instret 0 -> 1
    run_instr(find_op(6'h00, 6'h20), 1'b0, 1'b0, -1, 0, cyc);
    chk("add_cycles", cyc, 4);
    chk("add_instret", instret, 32'd1);

    // Every table entry with memory always ready
    for (int k = 0; k < tbl.size(); k++) begin
      run_instr(k, 1'($urandom_range(0, 1)), 1'b0, -1, 0, cyc);
      chk("tbl_cycles", cyc, base_cycles(tbl[k].cls));
    end

    // lw with three wait cycles in MEMRD
    run_instr(find_op(6'h23, 6'h00), 1'b0, 1'b0, S_MR, 3, cyc);
    chk("lw_stall_cycles", cyc, 8);
    // beq taken then not taken
    run_instr(find_op(6'h04, 6'h00), 1'b1, 1'b0, -1, 0, cyc);
    chk("beq_taken_cycles", cyc, 3);
    run_instr(find_op(6'h04, 6'h00), 1'b0, 1'b0, -1, 0, cyc);
    chk("beq_not_taken_cycles", cyc, 3);
    // fetch stalls add cycles one for one
    run_instr(find_op(6'h03, 6'h00), 1'b0, 1'b0, S_F, 2, cyc);
    chk("jal_fetch_stall_cycles", cyc, 5);
    // illegal opcode leaves instret unchanged
    run_instr(find_op(6'h3f, 6'h00), 1'b0, 1'b0, -1, 0, cyc);
    chk("illegal_cycles", cyc, 2);
    // sw with MEMWR stalls
    run_instr(find_op(6'h2b, 6'h00), 1'b0, 1'b0, S_MW, 2, cyc);
    chk("sw_stall_cycles", cyc, 6);

    // Randomized instruction stream with random memory stalls
    for (int r = 0; r < 80; r++) begin
      idx = $urandom_range(0, tbl.size() - 1);
      run_instr(idx, 1'($urandom_range(0, 1)), 1'b1, -1, 0, cyc);
    end

    // Reset asserted while a store waits in MEMWR
    Op = 6'h2b; Funct = 6'h00;
    @(negedge clk); mem_ready = 1'b1;   // FETCH
    @(negedge clk);                     // DECODE
    @(negedge clk); mem_ready = 1'b0;   // MEMADR
    @(negedge clk); #1;                 // MEMWR waiting
    chk("mw_state", state, 4'd5);
    chk("mw_MemWrite", MemWrite, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mw_rst_MemWrite", MemWrite, 1'b0);
    chk("mw_rst_state", state, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_state", state, 4'd0);
    chk("post_rst_MemRead", MemRead, 1'b1);
    chk("post_rst_instret", instret, 32'd0);
    exp_instret = 0;
    run_instr(find_op(6'h08, 6'h00), 1'b0, 1'b0, -1, 0, cyc);
    chk("post_rst_addi_cycles", cyc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
